ps2_joy_decoder: RTL and testbench

// - Turns the raw PS/2 keyboard pins from mist_io into a 10-bit active-high key map.
// - Sits between mist_io (ps2_kbd_clk/ps2_kbd_data) and the arcade top, which ORs joystick[9:0] into the control wires.
// - Contains a filtered PS/2 receiver, a prefix (E0/F0) state machine and a make/break key register.

---
 rtl/ps2_joy_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_joy_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_joy_decoder.sv
// PS/2 keyboard to 10-bit joystick map: synchronised and glitch-filtered receiver,
// E0/F0 prefix state machine and make/break key register.
module ps2_joy_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 18000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [9:0] joystick,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} pfx_t;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_q, filt_d;
  logic [7:0]    filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  pfx_t          pfx_q, pfx_d;
  logic [9:0]    joy_q, joy_d;

  logic fall;
  logic din;

  // One-hot joystick bit for a scan code; zero for codes that map to nothing.
  function automatic logic [9:0] key_mask(input logic [7:0] code, input logic ext);
    logic [9:0] m;
    m = '0;
    case ({ext, code})
      9'h029, 9'h014, 9'h114: m = 10'h001;
      9'h016:                 m = 10'h002;
      9'h01E:                 m = 10'h004;
      9'h02E:                 m = 10'h008;
      9'h175:                 m = 10'h010;
      9'h172:                 m = 10'h020;
      9'h16B:                 m = 10'h040;
      9'h174:                 m = 10'h080;
      9'h011, 9'h111:         m = 10'h100;
      9'h006:                 m = 10'h200;
      default:                m = 10'h000;
    endcase
    return m;
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latches).
    clk_sync_d  = {clk_sync_q[0], ps2_kbd_clk};
    data_sync_d = {data_sync_q[0], ps2_kbd_data};
    filt_d      = filt_q;
    filt_cnt_d  = filt_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_cnt_d   = tmo_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_err_d    = 1'b0;
    pfx_d       = pfx_q;
    joy_d       = joy_q;

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    if (clk_sync_q[1] == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
      filt_d     = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 8'd1;
    end

    fall = filt_q & ~filt_d;
    din  = data_sync_q[1];

    if (fall) begin
      tmo_cnt_d = '0;
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
        tmo_cnt_d = '0;
        bit_cnt_d = 4'd0;
        rx_err_d  = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    if (fall) begin
      case (bit_cnt_q)
        4'd0: if (!din) bit_cnt_d = 4'd1;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        4'd9: begin
          par_d     = din;
          bit_cnt_d = 4'd10;
        end
        default: begin
          bit_cnt_d = 4'd0;
          if (din && (^{shift_q, par_q})) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      endcase
    end

    if (rx_valid_q) begin
      case (pfx_q)
        IDLE: begin
          if (rx_data_q == 8'hE0)      pfx_d = EXT;
          else if (rx_data_q == 8'hF0) pfx_d = BRK;
          else                         joy_d = joy_q | key_mask(rx_data_q, 1'b0);
        end
        EXT: begin
          if (rx_data_q == 8'hF0)      pfx_d = EXTBRK;
          else if (rx_data_q == 8'hE0) pfx_d = EXT;
          else begin
            joy_d = joy_q | key_mask(rx_data_q, 1'b1);
            pfx_d = IDLE;
          end
        end
        BRK: begin
          joy_d = joy_q & ~key_mask(rx_data_q, 1'b0);
          pfx_d = IDLE;
        end
        default: begin
          joy_d = joy_q & ~key_mask(rx_data_q, 1'b1);
          pfx_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      pfx_q       <= IDLE;
      joy_q       <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      pfx_q       <= pfx_d;
      joy_q       <= joy_d;
    end
  end

  assign joystick = joy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_ps2_joy_decoder.sv
// Scoreboard bench for ps2_joy_decoder: stimulus queues expected receive events,
// a monitor pops them as rx_valid/rx_err appear and checks joystick one cycle later.
module tb_ps2_joy_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 40;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [9:0] joystick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  ps2_joy_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .joystick     (joystick),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_err       (rx_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [9:0] joy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  task automatic send_bit(input bit b);
    ps2_kbd_data = b;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    ps2_kbd_data = 1'b1;
    wait_cyc(HALF);
  endtask

  // Good frame: expect rx_data=d and joystick=j one cycle after rx_valid.
  task automatic rx(input logic [7:0] d, input logic [9:0] j);
    exp_q.push_back('{1'b0, d, j});
    send_frame(d, 1'b0);
  endtask

  task automatic rx_bad(input logic [7:0] d, input logic [9:0] j);
    exp_q.push_back('{1'b1, 8'h00, j});
    send_frame(d, 1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!reset && (rx_valid || rx_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b data=%h expected none",
                   rx_valid, rx_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_err", 32'(rx_err), 32'(e.is_err));
          check("rx_valid", 32'(rx_valid), 32'(!e.is_err));
          if (!e.is_err) check("rx_data", 32'(rx_data), 32'(e.data));
          @(negedge clk_sys);
          check("joystick", 32'(joystick), 32'(e.joy));
        end
      end
    end
  end

  initial begin
    wait_cyc(4);
    @(negedge clk_sys);
    check("reset_joystick", 32'(joystick), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_err", 32'(rx_err), 32'h0);
    @(posedge clk_sys);
    reset = 1'b0;
    wait_cyc(20);

    rx(8'h29, 10'h001);
    rx(8'hF0, 10'h001);
    rx(8'h29, 10'h000);

    rx(8'hE0, 10'h000);
    rx(8'h75, 10'h010);
    rx(8'hE0, 10'h010);
    rx(8'h6B, 10'h050);
    rx(8'hE0, 10'h050);
    rx(8'hF0, 10'h050);
    rx(8'h75, 10'h040);
    rx(8'hE0, 10'h040);
    rx(8'hF0, 10'h040);
    rx(8'h6B, 10'h000);

    rx_bad(8'h16, 10'h000);
    rx(8'h16, 10'h002);
    rx(8'hF0, 10'h002);
    rx(8'h16, 10'h000);

    // Partial frame then long idle: exactly one timeout error.
    exp_q.push_back('{1'b1, 8'h00, 10'h000});
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    ps2_kbd_data = 1'b1;
    wait_cyc(2 * TIMEOUT);
    rx(8'h2E, 10'h008);

    rx(8'h1C, 10'h008);
    rx(8'h75, 10'h008);

    // 2-cycle low glitch with data low would look like a start bit if counted.
    ps2_kbd_data = 1'b0;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(2);
    ps2_kbd_clk = 1'b1;
    wait_cyc(HALF);
    ps2_kbd_data = 1'b1;
    wait_cyc(HALF);
    rx(8'h29, 10'h009);
    rx(8'h29, 10'h009);

    rx(8'hF0, 10'h009);
    rx(8'h14, 10'h008);
    rx(8'hE0, 10'h008);
    rx(8'h14, 10'h009);

    // Reset mid-frame while in the E0 prefix state.
    rx(8'hE0, 10'h009);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_kbd_data = 1'b1;
    @(posedge clk_sys);
    reset = 1'b1;
    wait_cyc(3);
    @(negedge clk_sys);
    check("midreset_joystick", 32'(joystick), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    @(posedge clk_sys);
    reset = 1'b0;
    wait_cyc(20);
    rx(8'h75, 10'h000);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) wait_cyc(1);
    wait_cyc(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
